// File: rtl/mux_4_1.sv
// Registered 4-to-1 address-source selector for the 8-bit RISC datapath.
// Codes 0..2 load LRa / inca / ea1; code 3 holds the current output.
module mux_4_1 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] LRa,
    input  logic [7:0] inca,
    input  logic [7:0] ea1,
    input  logic [1:0] mux1CR,
    output logic [7:0] mux1op
);

    // No handshake: a new selection is taken on every rising edge,
    // and the result is visible one cycle later from the register only.
    logic [7:0] mux_q;
    logic [7:0] mux_d;

    always_comb begin
        mux_d = mux_q;
        case (mux1CR)
            2'd0:    mux_d = LRa;
            2'd1:    mux_d = inca;
            2'd2:    mux_d = ea1;
            default: mux_d = mux_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_q <= 8'h00;
        end else begin
            mux_q <= mux_d;
        end
    end

    assign mux1op = mux_q;

endmodule

// File: tb/tb_mux_4_1.sv
// Self-checking bench for mux_4_1: directed scenarios plus randomized
// traffic checked against a selection model and an expected-value queue.
module tb_mux_4_1;

    logic       clk;
    logic       rst;
    logic [7:0] LRa;
    logic [7:0] inca;
    logic [7:0] ea1;
    logic [1:0] mux1CR;
    logic [7:0] mux1op;

    int n_cmp;
    int n_err;

    logic [7:0] exp_q[$];

    mux_4_1 dut (
        .clk    (clk),
        .rst    (rst),
        .LRa    (LRa),
        .inca   (inca),
        .ea1    (ea1),
        .mux1CR (mux1CR),
        .mux1op (mux1op)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [1:0] code);
        LRa    = a;
        inca   = b;
        ea1    = c;
        mux1CR = code;
    endtask

    task automatic test_reset();
        drive(8'd81, 8'd83, 8'd45, 2'd0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mux1op !== 8'h00) begin
            n_err++;
            $display("FAIL reset_immediate: got %h expected 00", mux1op);
        end
        for (int i = 0; i < 4; i++) begin
            mux1CR = 2'(i);
            tick();
            n_cmp++;
            if (mux1op !== 8'h00) begin
                n_err++;
                $display("FAIL reset_held[%0d]: got %h expected 00", i, mux1op);
            end
        end
        mux1CR = 2'd0;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (mux1op !== 8'd81) begin
            n_err++;
            $display("FAIL reset_release_load: got %0d expected 81", mux1op);
        end
    endtask

    task automatic test_select();
        drive(8'd1, 8'd3, 8'd5, 2'd1);
        tick();
        n_cmp++;
        if (mux1op !== 8'd3) begin
            n_err++;
            $display("FAIL select1: got %0d expected 3", mux1op);
        end
        drive(8'd23, 8'd25, 8'd12, 2'd2);
        tick();
        n_cmp++;
        if (mux1op !== 8'd12) begin
            n_err++;
            $display("FAIL select2: got %0d expected 12", mux1op);
        end
    endtask

    task automatic test_hold();
        drive(8'd255, 8'd254, 8'd253, 2'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (mux1op !== 8'd12) begin
                n_err++;
                $display("FAIL hold[%0d]: got %0d expected 12", i, mux1op);
            end
        end
    endtask

    task automatic test_sampling();
        drive(8'd23, 8'd25, 8'd12, 2'd2);
        tick();
        #2;
        ea1 = 8'd99;
        #1;
        n_cmp++;
        if (mux1op !== 8'd12) begin
            n_err++;
            $display("FAIL sample_midcycle: got %0d expected 12", mux1op);
        end
        tick();
        n_cmp++;
        if (mux1op !== 8'd99) begin
            n_err++;
            $display("FAIL sample_next_edge: got %0d expected 99", mux1op);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [3];
        want[0] = 8'hFF;
        want[1] = 8'h00;
        want[2] = 8'hA5;
        LRa  = 8'hFF;
        inca = 8'h00;
        ea1  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            mux1CR = 2'(i);
            tick();
            n_cmp++;
            if (mux1op !== want[i]) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, mux1op, want[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        // Entered right after an edge that left mux1op = A5.
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mux1op !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: got %h expected 00", mux1op);
        end
        #1;
        rst = 1'b0;
        mux1CR = 2'd3;
        tick();
        n_cmp++;
        if (mux1op !== 8'h00) begin
            n_err++;
            $display("FAIL release_hold_zero: got %h expected 00", mux1op);
        end
    endtask

    task automatic test_random();
        logic [7:0] cand [3];
        logic [7:0] model;
        logic [1:0] code;
        logic [7:0] got;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model = 8'h00;
        for (int i = 0; i < 300; i++) begin
            cand[0] = 8'($urandom_range(0, 255));
            cand[1] = 8'($urandom_range(0, 255));
            cand[2] = 8'($urandom_range(0, 255));
            code    = 2'($urandom_range(0, 3));
            drive(cand[0], cand[1], cand[2], code);
            rst = ($urandom_range(0, 19) == 0);
            if (rst) begin
                #1;
                n_cmp++;
                if (mux1op !== 8'h00) begin
                    n_err++;
                    $display("FAIL rand_async_reset[%0d]: got %h expected 00", i, mux1op);
                end
                model = 8'h00;
            end else if (code != 2'd3) begin
                model = cand[code];
            end
            exp_q.push_back(model);
            tick();
            got = exp_q.pop_front();
            n_cmp++;
            if (mux1op !== got) begin
                n_err++;
                $display("FAIL rand_edge[%0d] code=%0d: got %h expected %h", i, code, mux1op, got);
            end
            drive(~cand[0], ~cand[1], ~cand[2], ~code);
            #1;
            n_cmp++;
            if (mux1op !== got) begin
                n_err++;
                $display("FAIL rand_stable[%0d]: got %h expected %h", i, mux1op, got);
            end
            rst = 1'b0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        drive(8'h00, 8'h00, 8'h00, 2'd3);
        @(negedge clk);
        test_reset();
        test_select();
        test_hold();
        test_sampling();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
